// File: rtl/bpb_table.sv
// Direct-mapped branch prediction buffer: same-cycle lookup, install/verify from the branch controller.
// Optional BPB_COUNTER_EN adds a 2-bit saturating confidence counter per line.
`ifndef BPB_E
`define BPB_E 8
`endif
`ifndef BPB_T
`define BPB_T 16
`endif

module bpb_line #(
  parameter int TAG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 set_valid,
  input  logic [TAG_WIDTH-1:0] set_tag,
  input  logic [31:0]          set_addr,
`ifdef BPB_COUNTER_EN
  input  logic                 upd,
  input  logic [1:0]           ctr_nxt,
  output logic [1:0]           ctr,
`endif
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] tag,
  output logic [31:0]          addr
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      addr  <= '0;
    end else if (wr) begin
      valid <= set_valid;
      tag   <= set_tag;
      addr  <= set_addr;
    end
  end

`ifdef BPB_COUNTER_EN
  // Install restarts confidence at weakly-taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ctr <= 2'b00;
    else if (wr)  ctr <= 2'b10;
    else if (upd) ctr <= ctr_nxt;
  end
`endif
endmodule

module bpb_table #(
  parameter int ENTRIES   = `BPB_E,
  parameter int TAG_WIDTH = `BPB_T,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_addr,
  input  logic                 w_en,
  input  logic                 sw,
  input  logic                 set_valid,
  input  logic [TAG_WIDTH-1:0] set_tag,
  input  logic [31:0]          set_addr,
  input  logic [31:0]          real_adr,
  output logic                 conflict,
  output logic [IDX_W:0]       num_valid
);
  logic [ENTRIES-1:0]                v_q;
  logic [ENTRIES-1:0][TAG_WIDTH-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]          addr_q;
  logic [IDX_W-1:0]                  lidx, widx;
  logic                              we, match_v, mism;

  assign lidx    = lookup_tag[IDX_W-1:0];
  assign widx    = set_tag[IDX_W-1:0];
  assign we      = w_en & ~stall & ~flush;
  assign hit     = v_q[lidx] & (tag_q[lidx] == lookup_tag);
  assign match_v = v_q[widx] & (tag_q[widx] == set_tag);
  assign mism    = addr_q[widx] != real_adr;
  assign pred_addr = hit ? addr_q[lidx] : 32'h0;

`ifdef BPB_COUNTER_EN
  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [1:0]              ctr_w, ctr_nxt;
  logic                    ue;

  assign ctr_w = ctr_q[widx];
  assign ue    = sw & ~w_en & ~stall & ~flush & match_v;
  // Confident lines absorb a mismatch by losing confidence instead of re-installing
  assign conflict   = sw & ~w_en & match_v & mism & ~ctr_w[1];
  assign pred_taken = hit & ctr_q[lidx][1];

  always_comb begin
    ctr_nxt = ctr_w;
    if (!mism) ctr_nxt = (ctr_w == 2'b11) ? 2'b11 : ctr_w + 2'b01;
    else if (ctr_w[1]) ctr_nxt = ctr_w - 2'b01;
  end
`else
  assign conflict   = sw & ~w_en & match_v & mism;
  assign pred_taken = hit;
`endif

  for (genvar i = 0; i < ENTRIES; i++) begin : g_line
    bpb_line #(.TAG_WIDTH(TAG_WIDTH)) u_line (
      .clk       (clk),
      .reset     (reset),
      .wr        (we & (widx == IDX_W'(i))),
      .set_valid (set_valid),
      .set_tag   (set_tag),
      .set_addr  (set_addr),
`ifdef BPB_COUNTER_EN
      .upd       (ue & (widx == IDX_W'(i))),
      .ctr_nxt   (ctr_nxt),
      .ctr       (ctr_q[i]),
`endif
      .valid     (v_q[i]),
      .tag       (tag_q[i]),
      .addr      (addr_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) num_valid <= '0;
    else if (we) begin
      if (set_valid && !v_q[widx] && num_valid != (IDX_W+1)'(ENTRIES))
        num_valid <= num_valid + 1'b1;
      else if (!set_valid && v_q[widx] && num_valid != '0)
        num_valid <= num_valid - 1'b1;
    end
  end
endmodule

// File: tb/tb_bpb_table.sv
// Scoreboard bench for bpb_table (ENTRIES=8, TAG_WIDTH=16); expectations follow BPB_COUNTER_EN.
module tb_bpb_table;
  logic        clk = 0, reset = 1, stall = 0, flush = 0;
  logic [15:0] lookup_tag = 0, set_tag = 0;
  logic        hit, pred_taken, conflict, w_en = 0, sw = 0, set_valid = 0;
  logic [31:0] pred_addr, set_addr = 0, real_adr = 0;
  logic [3:0]  num_valid;

  typedef struct {
    string       name;
    logic        hit, pt, conf;
    logic [31:0] addr;
    logic [3:0]  nv;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

`ifdef BPB_COUNTER_EN
  localparam bit CTR = 1;
`else
  localparam bit CTR = 0;
`endif

  bpb_table #(.ENTRIES(8), .TAG_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .lookup_tag(lookup_tag), .hit(hit), .pred_taken(pred_taken), .pred_addr(pred_addr),
    .w_en(w_en), .sw(sw), .set_valid(set_valid), .set_tag(set_tag), .set_addr(set_addr),
    .real_adr(real_adr), .conflict(conflict), .num_valid(num_valid)
  );

  always #5 clk = ~clk;

  // Monitor: compare outputs mid-cycle against whatever the stimulus queued
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (hit !== e.hit || pred_taken !== e.pt || pred_addr !== e.addr ||
          conflict !== e.conf || num_valid !== e.nv) begin
        errors++;
        $display("FAIL %s: got hit=%b pt=%b addr=%h conf=%b nv=%0d, want hit=%b pt=%b addr=%h conf=%b nv=%0d",
                 e.name, hit, pred_taken, pred_addr, conflict, num_valid,
                 e.hit, e.pt, e.addr, e.conf, e.nv);
      end
    end
  end

  task automatic drive(input logic rst, input logic [15:0] lt, input logic we, input logic s,
                       input logic sv, input logic [15:0] st, input logic [31:0] sa,
                       input logic [31:0] ra, input logic stl, input logic fl);
    @(posedge clk); #1;
    reset = rst; lookup_tag = lt; w_en = we; sw = s; set_valid = sv;
    set_tag = st; set_addr = sa; real_adr = ra; stall = stl; flush = fl;
  endtask

  task automatic expect_out(input string n, input logic h, input logic pt, input logic [31:0] a,
                            input logic c, input logic [3:0] nv);
    exp_t e;
    e.name = n; e.hit = h; e.pt = pt; e.addr = a; e.conf = c; e.nv = nv;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1, 16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0);
    // install 0x10 -> 0x400; same-cycle lookup sees old contents
    drive(0, 16'h10, 1, 0, 1, 16'h10, 32'h400, 0, 0, 0);
    expect_out("same_cycle_install", 0, 0, 0, 0, 0);
    drive(0, 16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("lookup_after_install", 1, 1, 32'h400, 0, 1);
    drive(0, 16'h10, 0, 1, 0, 16'h10, 0, 32'h400, 0, 0);
    expect_out("sw_match", 1, 1, 32'h400, 0, 1);
    drive(0, 16'h10, 0, 1, 0, 16'h10, 0, 32'h404, 0, 0);
    expect_out("sw_mismatch1", 1, 1, 32'h400, CTR ? 1'b0 : 1'b1, 1);
    drive(0, 16'h10, 0, 1, 0, 16'h10, 0, 32'h404, 0, 0);
    expect_out("sw_mismatch2", 1, 1, 32'h400, CTR ? 1'b0 : 1'b1, 1);
    drive(0, 16'h10, 0, 1, 0, 16'h10, 0, 32'h404, 0, 0);
    expect_out("sw_mismatch3", 1, CTR ? 1'b0 : 1'b1, 32'h400, 1, 1);
    drive(0, 16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("pred_after_mismatch", 1, CTR ? 1'b0 : 1'b1, 32'h400, 0, 1);
    // w_en wins over sw
    drive(0, 16'h10, 1, 1, 1, 16'h11, 32'h500, 32'h404, 0, 0);
    expect_out("wen_beats_sw", 1, CTR ? 1'b0 : 1'b1, 32'h400, 0, 1);
    // stalled install blocked; conflict still reported while stalled
    drive(0, 16'h11, 1, 0, 1, 16'h18, 32'h600, 0, 1, 0);
    expect_out("stall_install", 1, 1, 32'h500, 0, 2);
    drive(0, 16'h11, 0, 1, 0, 16'h10, 0, 32'h404, 1, 0);
    expect_out("stall_conflict", 1, 1, 32'h500, 1, 2);
    drive(0, 16'h10, 1, 0, 1, 16'h18, 32'h600, 0, 0, 1);
    expect_out("flush_install", 1, CTR ? 1'b0 : 1'b1, 32'h400, 0, 2);
    // eviction of 0x10 by 0x18 (same index)
    drive(0, 16'h10, 1, 0, 1, 16'h18, 32'h600, 0, 0, 0);
    expect_out("evict_same_cycle", 1, CTR ? 1'b0 : 1'b1, 32'h400, 0, 2);
    drive(0, 16'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("evicted_miss", 0, 0, 0, 0, 2);
    drive(0, 16'h18, 0, 1, 0, 16'h10, 0, 32'h999, 0, 0);
    expect_out("sw_evicted", 1, 1, 32'h600, 0, 2);
    // clear 0x11 with set_valid=0
    drive(0, 16'h11, 1, 0, 0, 16'h11, 32'h0, 0, 0, 0);
    expect_out("clear_same_cycle", 1, 1, 32'h500, 0, 2);
    drive(0, 16'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("cleared_miss", 0, 0, 0, 0, 1);
    // reset pulse during an install
    drive(1, 16'h18, 1, 0, 1, 16'h12, 32'h700, 0, 0, 0);
    expect_out("reset_mid_install", 0, 0, 0, 0, 0);
    drive(0, 16'h12, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("after_reset_12", 0, 0, 0, 0, 0);
    drive(0, 16'h18, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("after_reset_18", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
